// File: rtl/conv_relu_pool.sv
// Bias + ReLU + requantize stage followed by a streaming 2x2 max-pool.
// Pooled bytes come out two cycles after the input that closes each window.
module conv_relu_pool #(
  parameter int IN_W  = 21,
  parameter int MAP_W = 26,
  parameter int MAP_H = 26,
  parameter int SHIFT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic [IN_W-1:0] dot,
  input  logic            dot_valid,
  input  logic [15:0]     bias,
  output logic [7:0]      pool_data,
  output logic            pool_valid,
  output logic            frame_done
);

  localparam int SUM_W  = ((IN_W > 16) ? IN_W : 16) + 1;
  localparam int HALF_W = MAP_W / 2;
  localparam int COL_W  = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int ROW_W  = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] shifted;
  logic [7:0]       q_next;
  logic [7:0]       q;
  logic             q_valid;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [7:0]       hmax;
  logic [7:0]       pair;
  logic [7:0]       pooled;
  logic [7:0]       lb_rd;
  logic [IDX_W-1:0] lb_idx;
  logic             last_col;
  logic             last_row;
  logic [7:0]       line_buf [HALF_W];

  // Sign-extend both operands to a width where the add cannot overflow.
  always_comb begin
    sum     = {{(SUM_W-IN_W){dot[IN_W-1]}}, dot} + {{(SUM_W-16){bias[15]}}, bias};
    shifted = sum >> SHIFT;
    q_next  = 8'd0;
    if (sum[SUM_W-1] || (sum == '0)) begin
      q_next = 8'd0;
    end else if (|shifted[SUM_W-1:8]) begin
      q_next = 8'hFF;
    end else begin
      q_next = shifted[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= 8'd0;
      q_valid <= 1'b0;
    end else if (clr) begin
      q_valid <= 1'b0;
    end else begin
      q_valid <= dot_valid;
      if (dot_valid) begin
        q <= q_next;
      end
    end
  end

  always_comb begin
    lb_idx   = IDX_W'(col >> 1);
    lb_rd    = line_buf[lb_idx];
    pair     = (q > hmax) ? q : hmax;
    pooled   = (lb_rd > pair) ? lb_rd : pair;
    last_col = (col == COL_W'(MAP_W - 1));
    last_row = (row == ROW_W'(MAP_H - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      hmax       <= 8'd0;
      pool_data  <= 8'd0;
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
    end else if (clr) begin
      col        <= '0;
      row        <= '0;
      hmax       <= 8'd0;
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
      if (q_valid) begin
        if (!col[0]) begin
          hmax <= q;
        end else if (row[0]) begin
          pool_data  <= pooled;
          pool_valid <= 1'b1;
          frame_done <= last_row && last_col;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Never cleared: every entry is rewritten on an even row before it is read.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && q_valid && col[0] && !row[0]) begin
      line_buf[lb_idx] <= pair;
    end
  end

endmodule

// File: tb/tb_conv_relu_pool.sv
// Scoreboard bench for conv_relu_pool: three parameterisations share one stimulus
// bus and only the selected instance is checked against the bench's own model.
module tb_conv_relu_pool;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [20:0] dot;
  logic        dot_valid;
  logic [15:0] bias;

  logic [7:0] pd_a, pd_b, pd_c;
  logic       pv_a, pv_b, pv_c;
  logic       fd_a, fd_b, fd_c;

  always #5 clk = ~clk;

  conv_relu_pool #(.IN_W(21), .MAP_W(2), .MAP_H(2), .SHIFT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .dot(dot), .dot_valid(dot_valid), .bias(bias),
    .pool_data(pd_a), .pool_valid(pv_a), .frame_done(fd_a));

  conv_relu_pool #(.IN_W(21), .MAP_W(4), .MAP_H(2), .SHIFT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .dot(dot), .dot_valid(dot_valid), .bias(bias),
    .pool_data(pd_b), .pool_valid(pv_b), .frame_done(fd_b));

  conv_relu_pool #(.IN_W(21), .MAP_W(26), .MAP_H(26), .SHIFT(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .dot(dot), .dot_valid(dot_valid), .bias(bias),
    .pool_data(pd_c), .pool_valid(pv_c), .frame_done(fd_c));

  typedef struct {
    int data;
    int done;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int sel = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_pool = 0;
  int n_done = 0;
  int m_w, m_h, m_shift, m_col, m_row, m_hmax;
  int m_lb[0:12];

  logic [7:0] obs_data;
  logic       obs_valid;
  logic       obs_done;

  always_comb begin
    obs_data  = pd_c;
    obs_valid = pv_c;
    obs_done  = fd_c;
    case (sel)
      0: begin obs_data = pd_a; obs_valid = pv_a; obs_done = fd_a; end
      1: begin obs_data = pd_b; obs_valid = pv_b; obs_done = fd_b; end
      default: ;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs == expv) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
  endtask

  function automatic int quant(input int d, input int b, input int sh);
    int s;
    int t;
    s = d + b;
    if (s <= 0) return 0;
    t = s >> sh;
    return (t > 255) ? 255 : t;
  endfunction

  task automatic modelReset();
    m_col  = 0;
    m_row  = 0;
    m_hmax = 0;
    sb.delete();
  endtask

  // Drives one pulse and advances the reference pooling model alongside it.
  task automatic applyStimulus(input int d);
    int q;
    int pair;
    exp_t e;
    @(negedge clk);
    dot       = 21'(d);
    dot_valid = 1'b1;
    q = quant(d, int'($signed(bias)), m_shift);
    if ((m_col % 2) == 0) begin
      m_hmax = q;
    end else begin
      pair = (q > m_hmax) ? q : m_hmax;
      if ((m_row % 2) == 0) begin
        m_lb[m_col/2] = pair;
      end else begin
        e.data = (m_lb[m_col/2] > pair) ? m_lb[m_col/2] : pair;
        e.done = ((m_row == m_h-1) && (m_col == m_w-1)) ? 1 : 0;
        e.due  = cyc + 2;
        sb.push_back(e);
      end
    end
    if (m_col == m_w-1) begin
      m_col = 0;
      m_row = (m_row == m_h-1) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dot_valid = 1'b0;
    end
  endtask

  task automatic startTest(input int s, input int w, input int h, input int sh, input int b);
    @(negedge clk);
    sel = s; m_w = w; m_h = h; m_shift = sh;
    bias = 16'(b);
    clr = 1'b1;
    dot_valid = 1'b0;
    modelReset();
    n_pool = 0;
    n_done = 0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic endTest(input string tag, input int exp_pool, input int exp_done);
    idle(6);
    checkOutput({tag, "_pools"}, n_pool, exp_pool);
    checkOutput({tag, "_dones"}, n_done, exp_done);
    checkOutput({tag, "_drain"}, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (obs_valid) begin
      n_pool++;
      if (obs_done) n_done++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_pool", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("pool_data", int'(obs_data), mon_e.data);
        checkOutput("frame_done", int'(obs_done), mon_e.done);
        checkOutput("pool_time", cyc, mon_e.due);
      end
    end else if (obs_done) begin
      checkOutput("done_without_valid", 1, 0);
    end
  end

  int order_data[8] = '{2, 8, 6, 4, 10, 2, 0, 14};
  int before_clr;

  initial begin
    rst_n = 1'b0; clr = 1'b0; dot = '0; dot_valid = 1'b0; bias = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_data_a", int'(pd_a), 0);
    checkOutput("reset_valid_a", int'(pv_a), 0);
    checkOutput("reset_done_a", int'(fd_a), 0);
    checkOutput("reset_data_b", int'(pd_b), 0);
    checkOutput("reset_valid_b", int'(pv_b), 0);
    checkOutput("reset_data_c", int'(pd_c), 0);
    checkOutput("reset_valid_c", int'(pv_c), 0);
    rst_n = 1'b1;

    $display("[TB] requantization");
    startTest(0, 2, 2, 4, 24);
    applyStimulus(1000);
    applyStimulus(40);
    applyStimulus(100000);
    applyStimulus(-500);
    endTest("requant", 1, 1);

    $display("[TB] pooling order");
    startTest(1, 4, 2, 1, 0);
    foreach (order_data[i]) applyStimulus(order_data[i]);
    endTest("order", 2, 1);

    $display("[TB] gapped input");
    startTest(1, 4, 2, 1, 0);
    foreach (order_data[i]) begin
      applyStimulus(order_data[i]);
      idle(int'($urandom_range(3, 0)));
    end
    endTest("gapped", 2, 1);

    $display("[TB] multi-frame wrap");
    startTest(2, 26, 26, 8, 100);
    for (int i = 0; i < 3*676; i++) applyStimulus(int'($urandom_range(100000, 0)) - 20000);
    endTest("multi", 3*169, 3);

    $display("[TB] mid-frame clr");
    startTest(2, 26, 26, 8, -50);
    for (int i = 0; i < 30; i++) applyStimulus(int'($urandom_range(100000, 0)) - 20000);
    @(negedge clk);
    clr = 1'b1;
    dot = 21'd60000;
    dot_valid = 1'b1;
    sb.delete();
    before_clr = n_pool;
    @(negedge clk);
    clr = 1'b0;
    dot_valid = 1'b0;
    modelReset();
    idle(4);
    checkOutput("clr_abort_quiet", n_pool, before_clr);
    for (int i = 0; i < 676; i++) applyStimulus(int'($urandom_range(100000, 0)) - 20000);
    endTest("clr_frame", before_clr + 169, 1);

    $display("[TB] reset mid-operation");
    startTest(1, 4, 2, 1, 0);
    foreach (order_data[i]) applyStimulus(order_data[i]);
    @(negedge clk);
    rst_n = 1'b0;
    dot_valid = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput("rst_pool_data", int'(pd_b), 0);
    checkOutput("rst_pool_valid", int'(pv_b), 0);
    rst_n = 1'b1;
    foreach (order_data[i]) applyStimulus(order_data[i]);
    endTest("rst_frame", 3, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
